conv_tile_scheduler: RTL
========================

Name: conv_tile_scheduler

Overview:
- Frame-based layer sequencer for the conv array.
- Walks the tile loop nest oc > ic > h > w and issues weight loads and input-activation loads with ping-pong buffer selects.
- Enables the dataflow per tile and signals layer completion.
- Keeps busy and compute cycle counters, which the utilization monitor compares against conv_vld activity.

Parameters:
- CNT_W, 16, width of tile counts and loop indices.
- STAT_W, 32, width of the utilization cycle counters.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- layer_start  in  1  one-cycle pulse; samples cfg_* when IDLE.
- cfg_w_tiles  in  CNT_W  width tiles; also cfg_h_tiles, cfg_ic_tiles, cfg_oc_tiles (same width).
- weight_req  out  1  weight load request for the current (oc,ic).
- weight_ack  in  1  weight load complete.
- weight_buf_sel  out  1  weight buffer the datapath reads.
- input_loader_req  out  1  input tile load request.
- input_loader_ack  in  1  input load complete.
- input_buff_sel  out  1  input buffer the datapath reads.
- dataflow_en  out  1  conv array compute enable.
- tile_done  in  1  pulse from the datapath; current tile finished.
- w_idx, h_idx, ic_idx, oc_idx  out  CNT_W  current tile indices.
- busy  out  1  high from the cycle after an accepted layer_start until layer_done.
- layer_done  out  1  one-cycle completion pulse.
- stat_busy_cycles, stat_compute_cycles  out  STAT_W  utilization counters.

Behaviour:
- Reset: state IDLE. All outputs 0, including indices, buffer selects and stats. A reset mid-layer aborts immediately and issues no layer_done.
- States: IDLE, LOAD_W, LOAD_I, COMPUTE, DONE.
- IDLE, layer_start=1:
  - Latch cfg_*; clear indices and stats.
  - If any cfg count is 0, go to DONE: no requests, and layer_done pulses at cycle k+1.
  - Otherwise go to LOAD_W.
- layer_start while not IDLE: ignored. Latched cfg stays stable for the whole layer.
- Handshake rule (weight and input): req is high for the whole state. An ack sampled high while req=1 completes the transfer; req is 0 the following cycle. An ack without req is ignored. Zero-cycle ack is impossible: req is registered, so the earliest completion is 1 cycle after req rises.
- LOAD_W:
  - weight_req=1.
  - On weight_ack: toggle weight_buf_sel; go to LOAD_I.
- LOAD_I:
  - input_loader_req=1.
  - On input_loader_ack: toggle input_buff_sel; go to COMPUTE.
- COMPUTE:
  - dataflow_en=1.
  - tile_done outside COMPUTE is ignored.
  - On tile_done, dataflow_en drops next cycle and the indices advance with odometer wrap: w++; at w=cfg_w-1 wrap to 0 and h++; same for h→ic and ic→oc.
  - Last tile (all indices at max): go to DONE; indices hold their final values.
  - Else if the new w=0 and h=0 (the (oc,ic) pair changed): go to LOAD_W.
  - Else: go to LOAD_I.
- DONE: layer_done=1 for exactly one cycle; busy=0 in that cycle; next state IDLE.
- Latency: layer_start at edge k gives weight_req=1 in cycle k+1.
- Counts per layer:
  - weight loads = oc*ic.
  - input loads = oc*ic*h*w.
  - weight_buf_sel final value = parity of oc*ic; input_buff_sel final value = parity of the input load count.
- Stats:
  - stat_busy_cycles increments every cycle busy=1.
  - stat_compute_cycles increments every cycle dataflow_en=1.
  - Both saturate at all-ones and hold after layer_done until the next accepted layer_start.
- Simultaneous weight_ack and tile_done: only the one relevant to the current state is acted on.

Decomposition:
- Package conv_sched_pkg: state enum sched_state_e, CNT_W/STAT_W defaults, and a cfg struct tile_cfg_t {w,h,ic,oc}.
- One sub-module, tile_index_counter: the 4-level wrap odometer with last_tile and pair_change outputs.

Test Plan:
- cfg w=2,h=1,ic=1,oc=1, acks 1 cycle after req, tile_done after 3 cycles.
  - Expect 1 weight_req, 2 input_loader_req, and w_idx 0→1.
  - Expect input_buff_sel ending at 0 and weight_buf_sel ending at 1, with one layer_done.
- cfg w=2,h=2,ic=2,oc=2.
  - Expect 4 weight loads, 16 input loads, and a weight load only when w=h=0.
  - Expect final indices (1,1,1,1) and stat_compute_cycles equal to the sum of COMPUTE cycles.
- cfg h_tiles=0 with layer_start at cycle k.
  - Expect layer_done at k+1, no req ever, and stats 0.
- layer_start pulsed during COMPUTE, plus a stray tile_done during LOAD_I and a stray weight_ack during LOAD_I.
  - Expect all ignored and the sequence unchanged.
- rst asserted while weight_req=1.
  - Expect all outputs 0 next cycle and no layer_done.
  - A new layer_start then runs cleanly from index 0.
- weight_ack held high 5 cycles after the handshake.
  - Expect exactly one transfer, with weight_buf_sel toggling once.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// Shared types for the conv tile scheduler: FSM states, default widths and
// the latched per-layer tile configuration.
package conv_sched_pkg;

    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned STAT_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_I,
        COMPUTE,
        DONE
    } sched_state_e;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] w;
        logic [CNT_W_DEF-1:0] h;
        logic [CNT_W_DEF-1:0] ic;
        logic [CNT_W_DEF-1:0] oc;
    } tile_cfg_t;

    // An empty loop nest has no tiles; the layer completes without any loads.
    function automatic logic cfg_is_empty(tile_cfg_t c);
        return (c.w == '0) || (c.h == '0) || (c.ic == '0) || (c.oc == '0);
    endfunction

endpackage

// File: rtl/tile_index_counter.sv
// Four-level wrap odometer (oc > ic > h > w) for the tile loop nest, with
// flags for the final tile and for a change of the (oc,ic) pair.
module tile_index_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_adv,
    input  logic [CNT_W-1:0] i_w_tiles,
    input  logic [CNT_W-1:0] i_h_tiles,
    input  logic [CNT_W-1:0] i_ic_tiles,
    input  logic [CNT_W-1:0] i_oc_tiles,
    output logic [CNT_W-1:0] o_w_idx,
    output logic [CNT_W-1:0] o_h_idx,
    output logic [CNT_W-1:0] o_ic_idx,
    output logic [CNT_W-1:0] o_oc_idx,
    output logic             o_last_tile,
    output logic             o_pair_change
);

    logic [CNT_W-1:0] r_w;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_ic;
    logic [CNT_W-1:0] r_oc;
    logic             w_w_last;
    logic             w_h_last;
    logic             w_ic_last;
    logic             w_oc_last;

    assign w_w_last  = (r_w  == i_w_tiles  - CNT_W'(1));
    assign w_h_last  = (r_h  == i_h_tiles  - CNT_W'(1));
    assign w_ic_last = (r_ic == i_ic_tiles - CNT_W'(1));
    assign w_oc_last = (r_oc == i_oc_tiles - CNT_W'(1));

    // Advancing from here wraps both w and h, so the next tile starts a new (oc,ic) pair.
    assign o_pair_change = w_w_last && w_h_last;
    assign o_last_tile   = w_w_last && w_h_last && w_ic_last && w_oc_last;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_w  <= '0;
            r_h  <= '0;
            r_ic <= '0;
            r_oc <= '0;
        end else if (i_adv) begin
            if (!w_w_last) begin
                r_w <= r_w + CNT_W'(1);
            end else begin
                r_w <= '0;
                if (!w_h_last) begin
                    r_h <= r_h + CNT_W'(1);
                end else begin
                    r_h <= '0;
                    if (!w_ic_last) begin
                        r_ic <= r_ic + CNT_W'(1);
                    end else begin
                        r_ic <= '0;
                        r_oc <= w_oc_last ? '0 : r_oc + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign o_w_idx  = r_w;
    assign o_h_idx  = r_h;
    assign o_ic_idx = r_ic;
    assign o_oc_idx = r_oc;

endmodule

// File: rtl/conv_tile_scheduler.sv
// Layer sequencer: walks the tile loop nest, issues weight/input loads with
// ping-pong buffer selects, gates the conv dataflow and keeps utilization stats.
module conv_tile_scheduler
    import conv_sched_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned STAT_W = STAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              layer_start,
    input  logic [CNT_W-1:0]  cfg_w_tiles,
    input  logic [CNT_W-1:0]  cfg_h_tiles,
    input  logic [CNT_W-1:0]  cfg_ic_tiles,
    input  logic [CNT_W-1:0]  cfg_oc_tiles,
    output logic              weight_req,
    input  logic              weight_ack,
    output logic              weight_buf_sel,
    output logic              input_loader_req,
    input  logic              input_loader_ack,
    output logic              input_buff_sel,
    output logic              dataflow_en,
    input  logic              tile_done,
    output logic [CNT_W-1:0]  w_idx,
    output logic [CNT_W-1:0]  h_idx,
    output logic [CNT_W-1:0]  ic_idx,
    output logic [CNT_W-1:0]  oc_idx,
    output logic              busy,
    output logic              layer_done,
    output logic [STAT_W-1:0] stat_busy_cycles,
    output logic [STAT_W-1:0] stat_compute_cycles
);

    sched_state_e      r_state;
    sched_state_e      w_state_nxt;
    tile_cfg_t         r_cfg;
    tile_cfg_t         w_cfg_in;
    logic              r_wsel;
    logic              r_isel;
    logic [STAT_W-1:0] r_busy_cyc;
    logic [STAT_W-1:0] r_comp_cyc;
    logic              w_start;
    logic              w_adv;
    logic              w_last_tile;
    logic              w_pair_change;

    always_comb begin
        w_cfg_in    = '0;
        w_cfg_in.w  = CNT_W_DEF'(cfg_w_tiles);
        w_cfg_in.h  = CNT_W_DEF'(cfg_h_tiles);
        w_cfg_in.ic = CNT_W_DEF'(cfg_ic_tiles);
        w_cfg_in.oc = CNT_W_DEF'(cfg_oc_tiles);
    end

    assign w_start = (r_state == IDLE) && layer_start;

    tile_index_counter #(
        .CNT_W (CNT_W)
    ) u_tile_index_counter (
        .clk           (clk),
        .rst           (rst),
        .i_clr         (w_start),
        .i_adv         (w_adv),
        .i_w_tiles     (CNT_W'(r_cfg.w)),
        .i_h_tiles     (CNT_W'(r_cfg.h)),
        .i_ic_tiles    (CNT_W'(r_cfg.ic)),
        .i_oc_tiles    (CNT_W'(r_cfg.oc)),
        .o_w_idx       (w_idx),
        .o_h_idx       (h_idx),
        .o_ic_idx      (ic_idx),
        .o_oc_idx      (oc_idx),
        .o_last_tile   (w_last_tile),
        .o_pair_change (w_pair_change)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_adv            = 1'b0;
        weight_req       = 1'b0;
        input_loader_req = 1'b0;
        dataflow_en      = 1'b0;
        busy             = 1'b0;
        layer_done       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (layer_start) begin
                    w_state_nxt = cfg_is_empty(w_cfg_in) ? DONE : LOAD_W;
                end
            end
            LOAD_W: begin
                weight_req = 1'b1;
                busy       = 1'b1;
                if (weight_ack) begin
                    w_state_nxt = LOAD_I;
                end
            end
            LOAD_I: begin
                input_loader_req = 1'b1;
                busy             = 1'b1;
                if (input_loader_ack) begin
                    w_state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                dataflow_en = 1'b1;
                busy        = 1'b1;
                if (tile_done) begin
                    if (w_last_tile) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_adv       = 1'b1;
                        w_state_nxt = w_pair_change ? LOAD_W : LOAD_I;
                    end
                end
            end
            DONE: begin
                layer_done  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cfg      <= '0;
            r_wsel     <= 1'b0;
            r_isel     <= 1'b0;
            r_busy_cyc <= '0;
            r_comp_cyc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_cfg      <= w_cfg_in;
                r_wsel     <= 1'b0;
                r_isel     <= 1'b0;
                r_busy_cyc <= '0;
                r_comp_cyc <= '0;
            end else begin
                if ((r_state == LOAD_W) && weight_ack) begin
                    r_wsel <= ~r_wsel;
                end
                if ((r_state == LOAD_I) && input_loader_ack) begin
                    r_isel <= ~r_isel;
                end
                // Saturating counters: hold at all-ones rather than wrap.
                if (busy && (r_busy_cyc != '1)) begin
                    r_busy_cyc <= r_busy_cyc + STAT_W'(1);
                end
                if (dataflow_en && (r_comp_cyc != '1)) begin
                    r_comp_cyc <= r_comp_cyc + STAT_W'(1);
                end
            end
        end
    end

    assign weight_buf_sel      = r_wsel;
    assign input_buff_sel      = r_isel;
    assign stat_busy_cycles    = r_busy_cyc;
    assign stat_compute_cycles = r_comp_cyc;

endmodule
